button_debounce: RTL and testbench

- Upstream conditioning stage for level_to_pulse. Takes a raw, asynchronous, bouncing push-button/switch input and produces a clean, synchronous level `L`.
- `L` connects directly to the `L` input of level_to_pulse, so one physical press yields exactly one `P` pulse.
- Contains a 2-flop synchronizer, a stability counter and a 4-state debounce FSM.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/button_debounce.sv | 132 +++++++++++++
 tb/tb_button_debounce.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state encoding and constants for button_debounce.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int GLITCH_W = 8;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer with synchronous reset for async inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_sync_0;
  logic r_sync_1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_0 <= 1'b0;
      r_sync_1 <= 1'b0;
    end else begin
      r_sync_0 <= d;
      r_sync_1 <= r_sync_0;
    end
  end

  assign q = r_sync_1;

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module      : button_debounce
// Description : Synchronizes and debounces a raw button into a clean level L.
//               Optional macro DEBOUNCE_GLITCH_CNT_EN adds a saturating
//               rejected-transition counter on port glitch_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_in,
  output logic                L,
  output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_sync;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_L;
  logic             r_busy;
  logic             w_L_nxt;
  logic             w_busy_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE_LOW: begin
        if (w_sync) begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = IDLE_HIGH;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!w_sync) begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (w_sync) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they change in the same cycle as the FSM.
  assign w_L_nxt    = (w_state_nxt == IDLE_HIGH) || (w_state_nxt == WAIT_LOW);
  assign w_busy_nxt = (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_L     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_L     <= w_L_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign L    = r_L;
  assign busy = r_busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                r_glitch_cnt;
  logic [GLITCH_W-1:0] r_glitch;
  logic                w_abort;

  assign w_abort = ((r_state == WAIT_HIGH) && !w_sync) ||
                   ((r_state == WAIT_LOW)  &&  w_sync);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch <= '0;
    end else if (w_abort && (r_glitch != '1)) begin
      r_glitch <= r_glitch + 1'b1;
    end
  end

  assign r_glitch_cnt = 1'b0;
  assign glitch_cnt   = r_glitch;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ============================================================================
// Module      : tb_button_debounce
// Description : Self-checking bench for button_debounce (STABLE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debounce;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic L;
  logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  button_debounce #(
    .STABLE_CYCLES(S),
    .CNT_W        (16)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .L      (L),
    .busy   (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  // Model: the FSM sees btn_in two edges late; L flips once the seen level has
  // disagreed with L for S+1 consecutive edges, any agreement inside a run is a glitch.
  bit m_b0 = 0, m_b1 = 0, m_L = 0, m_busy = 0;
  int m_run = 0, m_glitch = 0;
  always @(posedge clk) begin
    bit s;
    if (rst) begin
      m_b0 = 0; m_b1 = 0; m_L = 0; m_busy = 0; m_run = 0; m_glitch = 0;
    end else begin
      s = m_b1; m_b1 = m_b0; m_b0 = btn_in;
      if (s != m_L) begin
        m_run++;
        if (m_run == S + 1) begin
          m_L   = !m_L;
          m_run = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
      m_busy = (m_run > 0);
    end
  end

  // Downstream level_to_pulse behaviour and busy duty, sampled before NBA updates.
  int d_rises = 0, busy_cnt = 0;
  logic prev_L = 1'b0;
  always @(posedge clk) begin
    if (chk_en) begin
      if (L && !prev_L) d_rises++;
      if (busy) busy_cnt++;
      prev_L = L;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_L", {31'd0, L}, {31'd0, m_L});
      check("model_busy", {31'd0, busy}, {31'd0, m_busy});
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("model_glitch", {24'd0, glitch_cnt}, m_glitch);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int r0, b0, g0;

  initial begin
    rst = 1'b1; btn_in = 1'b0;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    check("reset_L", {31'd0, L}, 0);
    check("reset_busy", {31'd0, busy}, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("reset_glitch", {24'd0, glitch_cnt}, 0);
`endif
    rst = 1'b0;
    cyc(2);

    // Clean press
    r0 = d_rises; b0 = busy_cnt;
    btn_in = 1'b1;
    cyc(6); check("press_L_edge5", {31'd0, L}, 0);
    cyc(1); check("press_L_edge6", {31'd0, L}, 1);
    cyc(14);
    check("press_busy_cycles", busy_cnt - b0, 4);
    check("press_one_pulse", d_rises - r0, 1);
    check("press_model_L", {31'd0, m_L}, 1);

    // Release
    btn_in = 1'b0;
    cyc(6); check("release_L_edge5", {31'd0, L}, 1);
    cyc(1); check("release_L_edge6", {31'd0, L}, 0);
    cyc(10);

    // Bounce 1,0,1,0 then hold 1
    r0 = d_rises; g0 = m_glitch;
    btn_in = 1'b1; cyc(1);
    btn_in = 1'b0; cyc(1);
    btn_in = 1'b1; cyc(1);
    btn_in = 1'b0; cyc(1);
    btn_in = 1'b1;
    cyc(6); check("bounce_L_edge5", {31'd0, L}, 0);
    cyc(1); check("bounce_L_edge6", {31'd0, L}, 1);
    cyc(10);
    check("bounce_one_pulse", d_rises - r0, 1);
    check("bounce_model_glitches", m_glitch - g0, 2);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("bounce_glitch_cnt", {24'd0, glitch_cnt}, g0 + 2);
`endif
    btn_in = 1'b0;
    cyc(12);

    // Short high glitch
    g0 = m_glitch;
    btn_in = 1'b1; cyc(3);
    btn_in = 1'b0; cyc(10);
    check("short_L", {31'd0, L}, 0);
    check("short_busy", {31'd0, busy}, 0);
    check("short_model_glitch", m_glitch - g0, 1);

    // Short low glitch while L=1
    btn_in = 1'b1; cyc(10);
    check("hold_L", {31'd0, L}, 1);
    g0 = m_glitch;
    btn_in = 1'b0; cyc(3);
    btn_in = 1'b1; cyc(10);
    check("lowglitch_L", {31'd0, L}, 1);
    check("lowglitch_model_glitch", m_glitch - g0, 1);
    btn_in = 1'b0; cyc(10);
    check("lowglitch_release_L", {31'd0, L}, 0);

    // Reset during WAIT_HIGH with cnt=2
    btn_in = 1'b1;
    cyc(5);
    check("midwait_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    cyc(1);
    check("midrst_L", {31'd0, L}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("midrst_glitch", {24'd0, glitch_cnt}, 0);
`endif
    rst = 1'b0;
    cyc(6); check("postrst_L_edge5", {31'd0, L}, 0);
    cyc(1); check("postrst_L_edge6", {31'd0, L}, 1);
    btn_in = 1'b0;
    cyc(10);

    // Saturation: 300 single-cycle glitches
    for (int i = 0; i < 300; i++) begin
      btn_in = 1'b1; cyc(1);
      btn_in = 1'b0; cyc(2);
    end
    cyc(4);
    check("sat_L", {31'd0, L}, 0);
    check("sat_model_glitch", m_glitch, 255);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("sat_glitch_cnt", {24'd0, glitch_cnt}, 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
